// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Defines the fetch FSM states, the IF/ID register layout and the PC increment helper.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    REDIRECT
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  function automatic logic [31:0] pc_add(input logic [31:0] pc, input int unsigned step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_fetch_stage_pipe_reg.sv
// Generic pipeline register with asynchronous reset, load enable and synchronous clear.
// The clear input takes priority over the load enable.
module pipe_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory request FSM and IF/ID capture.
// Handles stall, flush and variable memory latency; counts stalled/waiting cycles.
module if_fetch_stage
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_next_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             imem_ready_i,
  input  logic [31:0]      imem_rdata_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic             ifid_valid_o,
  output logic [31:0]      ifid_pc_o,
  output logic [31:0]      ifid_pc_plus4_o,
  output logic [31:0]      ifid_instr_o,
  output logic             fetch_wait_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redirect_q, redirect_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fetch_wait;
  logic [31:0]      pc_plus4;
  logic             ifid_en;
  logic             ifid_clr;
  ifid_t            ifid_d;
  ifid_t            ifid_q;

  assign pc_plus4   = pc_add(pc_q, PC_STEP);
  assign fetch_wait = req_q & ~imem_ready_i;
  assign ifid_d     = '{valid: 1'b1, pc: pc_q, pc_plus4: pc_plus4, instr: imem_rdata_i};

  // The address must not move while a request is outstanding, so a flush
  // during a wait parks its target in redirect_q until the memory answers.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready_i) begin
          if (flush_i) begin
            ifid_clr = 1'b1;
            pc_d     = pc_next_i;
          end else if (!stall_i) begin
            ifid_en = 1'b1;
            pc_d    = pc_next_i;
          end
        end else begin
          if (flush_i) begin
            ifid_clr   = 1'b1;
            redirect_d = pc_next_i;
            state_d    = REDIRECT;
          end else if (!stall_i) begin
            ifid_clr = 1'b1;
          end
        end
      end
      REDIRECT: begin
        ifid_clr = flush_i | ~stall_i;
        if (flush_i) begin
          redirect_d = pc_next_i;
        end
        if (imem_ready_i) begin
          pc_d    = flush_i ? pc_next_i : redirect_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    req_d = (state_d != BOOT);

    cnt_d = cnt_q;
    if ((stall_i | fetch_wait) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      redirect_q <= RESET_PC;
      req_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
    end
  end

  pipe_reg #(
    .W($bits(ifid_t))
  ) u_ifid_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (ifid_en),
    .clr_i (ifid_clr),
    .d_i   (ifid_d),
    .q_o   (ifid_q)
  );

  assign imem_req_o      = req_q;
  assign imem_addr_o     = pc_q;
  assign pc_o            = pc_q;
  assign pc_plus4_o      = pc_plus4;
  assign fetch_wait_o    = fetch_wait;
  assign stall_cnt_o     = cnt_q;
  assign ifid_valid_o    = ifid_q.valid;
  assign ifid_pc_o       = ifid_q.pc;
  assign ifid_pc_plus4_o = ifid_q.pc_plus4;
  assign ifid_instr_o    = ifid_q.valid ? ifid_q.instr : NOP_WORD;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model of the fetch stage.
`timescale 1ns/1ps
module tb_if_fetch_stage;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic [31:0]      pc_next_i;
  logic             stall_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             imem_ready_i = 1'b0;
  logic [31:0]      imem_rdata_i = 32'h0;
  logic             imem_req_o;
  logic [31:0]      imem_addr_o;
  logic [31:0]      pc_o;
  logic [31:0]      pc_plus4_o;
  logic             ifid_valid_o;
  logic [31:0]      ifid_pc_o;
  logic [31:0]      ifid_pc_plus4_o;
  logic [31:0]      ifid_instr_o;
  logic             fetch_wait_o;
  logic [CNT_W-1:0] stall_cnt_o;

  // The PC-source mux lives in the bench: sequential fetch or a branch target.
  logic        use_branch = 1'b0;
  logic [31:0] branch_tgt = 32'h0;
  assign pc_next_i = use_branch ? branch_tgt : pc_plus4_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_next_i       (pc_next_i),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .imem_ready_i    (imem_ready_i),
    .imem_rdata_i    (imem_rdata_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o),
    .ifid_valid_o    (ifid_valid_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
    .ifid_instr_o    (ifid_instr_o),
    .fetch_wait_o    (fetch_wait_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  // Behavioural model: "booting" is the single idle cycle after reset, "pending"
  // means a redirect target is waiting for the in-flight fetch to finish.
  logic        m_booting = 1'b1;
  logic [31:0] m_pc      = 32'h0;
  logic        m_pending = 1'b0;
  logic [31:0] m_target  = 32'h0;
  logic        m_valid   = 1'b0;
  logic [31:0] m_ipc     = 32'h0;
  logic [31:0] m_ipc4    = 32'h0;
  logic [31:0] m_instr   = 32'h0;
  int          m_cnt     = 0;

  logic [31:0] m_next;
  logic        m_wait;
  assign m_next = use_branch ? branch_tgt : m_pc + 32'd4;
  assign m_wait = !m_booting && !imem_ready_i;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_booting <= 1'b1;
      m_pc      <= 32'h0;
      m_pending <= 1'b0;
      m_target  <= 32'h0;
      m_valid   <= 1'b0;
      m_ipc     <= 32'h0;
      m_ipc4    <= 32'h0;
      m_instr   <= 32'h0;
      m_cnt     <= 0;
    end else begin
      if ((stall_i || m_wait) && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      if (m_booting) begin
        m_booting <= 1'b0;
      end else if (imem_ready_i) begin
        if (flush_i || (m_pending && !stall_i)) begin
          m_valid <= 1'b0; m_ipc <= 32'h0; m_ipc4 <= 32'h0; m_instr <= 32'h0;
        end else if (!m_pending && !stall_i) begin
          m_valid <= 1'b1; m_ipc <= m_pc; m_ipc4 <= m_pc + 32'd4; m_instr <= imem_rdata_i;
        end
        if (flush_i) m_pc <= m_next;
        else if (m_pending) m_pc <= m_target;
        else if (!stall_i) m_pc <= m_next;
        m_pending <= 1'b0;
      end else begin
        if (flush_i || !stall_i) begin
          m_valid <= 1'b0; m_ipc <= 32'h0; m_ipc4 <= 32'h0; m_instr <= 32'h0;
        end
        if (flush_i) begin
          m_pending <= 1'b1;
          m_target  <= m_next;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge, all outputs are compared against the model.
  always @(negedge clk_i) begin
    checkOutput("imem_req",   32'(imem_req_o),   32'(!m_booting));
    checkOutput("imem_addr",  imem_addr_o,       m_pc);
    checkOutput("pc",         pc_o,              m_pc);
    checkOutput("pc_plus4",   pc_plus4_o,        m_pc + 32'd4);
    checkOutput("fetch_wait", 32'(fetch_wait_o), 32'(m_wait));
    checkOutput("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
    checkOutput("ifid_instr", ifid_instr_o,      m_instr);
    checkOutput("stall_cnt",  32'(stall_cnt_o),  32'(m_cnt));
    if (m_valid) begin
      checkOutput("ifid_pc",       ifid_pc_o,       m_ipc);
      checkOutput("ifid_pc_plus4", ifid_pc_plus4_o, m_ipc4);
    end
  end

  task automatic applyStimulus(input logic stall, input logic flush, input logic ready,
                               input logic [31:0] rdata, input logic branch, input logic [31:0] tgt);
    stall_i      = stall;
    flush_i      = flush;
    imem_ready_i = ready;
    imem_rdata_i = rdata;
    use_branch   = branch;
    branch_tgt   = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    repeat (2) tick();
    checkOutput("rst_pc",        pc_o,                 32'h0);
    checkOutput("rst_req",       32'(imem_req_o),      32'h0);
    checkOutput("rst_valid",     32'(ifid_valid_o),    32'h0);
    checkOutput("rst_ifid_pc",   ifid_pc_o,            32'h0);
    checkOutput("rst_ifid_pc4",  ifid_pc_plus4_o,      32'h0);
    checkOutput("rst_cnt",       32'(stall_cnt_o),     32'h0);
    rst_i = 1'b0;

    // Sequential zero-wait fetch after the BOOT cycle.
    applyStimulus(0, 0, 1, 32'hDEAD_0000, 0, 32'h0);
    checkOutput("boot_req", 32'(imem_req_o), 32'h0);
    tick();
    checkOutput("fetch_req",   32'(imem_req_o),   32'h1);
    checkOutput("boot_nocap",  32'(ifid_valid_o), 32'h0);
    applyStimulus(0, 0, 1, 32'hA000_0000, 0, 32'h0);
    tick();
    checkOutput("seq_ifid_pc0", ifid_pc_o, 32'h0);
    checkOutput("seq_instr0",   ifid_instr_o, 32'hA000_0000);
    checkOutput("model_ipc0",   m_ipc, 32'h0);
    applyStimulus(0, 0, 1, 32'hA000_0004, 0, 32'h0);
    tick();
    checkOutput("seq_ifid_pc4", ifid_pc_o, 32'h4);
    checkOutput("seq_valid",    32'(ifid_valid_o), 32'h1);
    checkOutput("model_ipc4",   m_ipc, 32'h4);

    // Memory not ready for three cycles at pc 8.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 32'hBAD0_0008, 0, 32'h0);
      checkOutput("wait_flag", 32'(fetch_wait_o), 32'h1);
      checkOutput("wait_addr", imem_addr_o, 32'h8);
      tick();
      checkOutput("wait_bubble", 32'(ifid_valid_o), 32'h0);
    end
    checkOutput("wait_cnt", 32'(stall_cnt_o), 32'h3);
    checkOutput("model_cnt3", 32'(m_cnt), 32'h3);
    applyStimulus(0, 0, 1, 32'hA000_0008, 0, 32'h0);
    tick();
    checkOutput("after_wait_pc", ifid_pc_o, 32'h8);
    checkOutput("after_wait_pc_reg", pc_o, 32'hC);

    // Stall two cycles while memory answers at pc C.
    applyStimulus(1, 0, 1, 32'hBAD0_000C, 0, 32'h0);
    repeat (2) tick();
    checkOutput("stall_pc_hold",   pc_o, 32'hC);
    checkOutput("stall_ifid_hold", ifid_pc_o, 32'h8);
    checkOutput("stall_cnt", 32'(stall_cnt_o), 32'h5);
    applyStimulus(0, 0, 1, 32'hA000_000C, 0, 32'h0);
    tick();
    checkOutput("unstall_ifid_pc", ifid_pc_o, 32'hC);
    checkOutput("unstall_instr",   ifid_instr_o, 32'hA000_000C);

    // Flush with ready: bubble, then the target instruction.
    applyStimulus(0, 1, 1, 32'hBAD0_0010, 1, 32'h40);
    tick();
    checkOutput("flush_bubble", 32'(ifid_valid_o), 32'h0);
    checkOutput("flush_instr0", ifid_instr_o, 32'h0);
    checkOutput("flush_pc",     pc_o, 32'h40);
    applyStimulus(0, 0, 1, 32'hA000_0040, 0, 32'h0);
    tick();
    checkOutput("tgt_ifid_pc",  ifid_pc_o, 32'h40);
    checkOutput("tgt_ifid_pc4", ifid_pc_plus4_o, 32'h44);
    checkOutput("tgt_instr",    ifid_instr_o, 32'hA000_0040);

    // Stall and flush together: flush wins.
    applyStimulus(1, 1, 1, 32'hBAD0_0044, 1, 32'h10);
    tick();
    checkOutput("sf_bubble", 32'(ifid_valid_o), 32'h0);
    checkOutput("sf_pc",     pc_o, 32'h10);

    // Flush while waiting: address held, then redirect on ready.
    applyStimulus(0, 1, 0, 32'hBAD0_0010, 1, 32'h80);
    tick();
    checkOutput("redir_addr_hold", imem_addr_o, 32'h10);
    applyStimulus(0, 0, 0, 32'hBAD0_0010, 0, 32'h0);
    checkOutput("redir_wait", 32'(fetch_wait_o), 32'h1);
    tick();
    applyStimulus(0, 0, 1, 32'hBAD0_0010, 0, 32'h0);
    tick();
    checkOutput("redir_drop", 32'(ifid_valid_o), 32'h0);
    checkOutput("redir_addr", imem_addr_o, 32'h80);
    checkOutput("redir_cnt",  32'(stall_cnt_o), 32'h8);

    // PC wrap at the top of the address space.
    applyStimulus(0, 1, 1, 32'hBAD0_0080, 1, 32'hFFFF_FFFC);
    tick();
    applyStimulus(0, 0, 1, 32'hA0FF_FFFC, 0, 32'h0);
    checkOutput("wrap_pc_plus4", pc_plus4_o, 32'h0);
    tick();
    checkOutput("wrap_ifid_pc4", ifid_pc_plus4_o, 32'h0);
    checkOutput("wrap_pc",       pc_o, 32'h0);

    // Asynchronous reset in the middle of a stalled wait.
    applyStimulus(0, 0, 1, 32'hA000_0000, 0, 32'h0);
    tick();
    applyStimulus(1, 0, 0, 32'hBAD0_0004, 0, 32'h0);
    tick();
    #2 rst_i = 1'b1;
    #1;
    checkOutput("arst_pc",    pc_o, 32'h0);
    checkOutput("arst_req",   32'(imem_req_o), 32'h0);
    checkOutput("arst_wait",  32'(fetch_wait_o), 32'h0);
    checkOutput("arst_valid", 32'(ifid_valid_o), 32'h0);
    checkOutput("arst_cnt",   32'(stall_cnt_o), 32'h0);
    applyStimulus(0, 0, 1, 32'hBAD0_0000, 0, 32'h0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    tick();
    checkOutput("late_ready_ignored", 32'(ifid_valid_o), 32'h0);
    checkOutput("late_ready_pc",      pc_o, 32'h0);

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic fl;
      if ($urandom_range(0, 149) == 0) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
      end
      fl = ($urandom_range(0, 99) < 10);
      applyStimulus($urandom_range(0, 99) < 15, fl, $urandom_range(0, 99) < 70, $urandom(),
                    fl || ($urandom_range(0, 99) < 5), $urandom() & 32'hFFFF_FFFC);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
